// File: rtl/mux_demux_route_arb_pkg.sv
// Shared types and datapath defaults for the routed 1024-channel mux/demux path.
package mux_demux_route_arb_pkg;

  localparam int DEF_SEL_W    = 10;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_DST_MAX  = 999;
  localparam int DEF_PIPE_LAT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mux_demux_route_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/mux_demux_route_arb.sv
// Round-robin arbiter sharing the registered mux/demux path; drives selects for each
// granted hold window and flags completion once the last output has drained.
//
//   state | meaning
//   IDLE  | no route on the selects; selects keep their last value
//   HOLD  | selects carry owner's route; cnt counts down to the last hold cycle
module mux_demux_route_arb
  import mux_demux_route_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int DST_MAX  = DEF_DST_MAX,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*SEL_W-1:0]     src_sel,
  input  logic [NREQ*SEL_W-1:0]     dst_sel,
  input  logic [NREQ*LEN_W-1:0]     len,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           err,
  output logic [NREQ-1:0]           done,
  output logic [SEL_W-1:0]          mux_sel,
  output logic [SEL_W-1:0]          demux_sel,
  output logic                      route_busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int OW = $clog2(NREQ);
  localparam logic [SEL_W-1:0] DST_LIM = SEL_W'(DST_MAX);
  localparam int TL = PIPE_LAT - 2;

  state_t            state;
  logic [OW-1:0]     ptr;
  logic [OW-1:0]     ptr_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [NREQ-1:0]   cand;
  logic [OW-1:0]     win;
  logic              win_v;
  logic              win_ok;
  logic              win_bad;
  logic              arb_en;
  logic              last_hold;
  logic [SEL_W-1:0]  win_src;
  logic [SEL_W-1:0]  win_dst;
  logic [LEN_W-1:0]  win_len;
  logic [NREQ-1:0]   win_hot;

  // Masking with last cycle's grant keeps a len=0 owner from winning again immediately.
  assign cand = req & ~gnt;

  rr_pick #(.N(NREQ), .IDX_W(OW)) u_pick (
    .req       (cand),
    .ptr       (ptr),
    .winner    (win),
    .any_valid (win_v)
  );

  assign win_src   = src_sel[int'(win)*SEL_W +: SEL_W];
  assign win_dst   = dst_sel[int'(win)*SEL_W +: SEL_W];
  assign win_len   = len[int'(win)*LEN_W +: LEN_W];
  assign win_hot   = NREQ'(1) << win;
  assign win_ok    = win_v && (win_dst <= DST_LIM);
  assign win_bad   = win_v && (win_dst > DST_LIM);
  assign ptr_nxt   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  assign last_hold = (state == HOLD) && (cnt == '0);
  assign arb_en    = (state == IDLE) || last_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      err        <= '0;
      mux_sel    <= '0;
      demux_sel  <= '0;
      route_busy <= 1'b0;
      owner      <= '0;
    end else begin
      gnt <= '0;
      err <= '0;
      if (arb_en) begin
        if (win_v) ptr <= ptr_nxt;
        if (win_bad) err <= win_hot;
        if (win_ok) begin
          gnt        <= win_hot;
          mux_sel    <= win_src;
          demux_sel  <= win_dst;
          cnt        <= win_len;
          owner      <= win;
          route_busy <= 1'b1;
          state      <= HOLD;
        end else begin
          route_busy <= 1'b0;
          state      <= IDLE;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Completion tags: one stage per datapath register, the last stage feeding done.
  logic [TL:0]   tag_v;
  logic [OW-1:0] tag_o [0:TL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k <= TL; k++) tag_o[k] <= '0;
      done  <= '0;
    end else begin
      tag_v[0] <= last_hold;
      tag_o[0] <= owner;
      for (int k = 1; k <= TL; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_o[k] <= tag_o[k-1];
      end
      done <= tag_v[TL] ? (NREQ'(1) << tag_o[TL]) : '0;
    end
  end

endmodule

// File: tb/tb_mux_demux_route_arb.sv
// Scoreboard bench for mux_demux_route_arb: expected grants/errors queued at stimulus time,
// done expectations derived from observed grants and checked for order and timing.
module tb_mux_demux_route_arb;

  localparam int NREQ = 4;
  localparam int SEL_W = 10;
  localparam int LEN_W = 8;
  localparam int PIPE_LAT = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*SEL_W-1:0] src_sel;
  logic [NREQ*SEL_W-1:0] dst_sel;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       err;
  logic [NREQ-1:0]       done;
  logic [SEL_W-1:0]      mux_sel;
  logic [SEL_W-1:0]      demux_sel;
  logic                  route_busy;
  logic [1:0]            owner;

  mux_demux_route_arb #(.NREQ(NREQ), .SEL_W(SEL_W), .LEN_W(LEN_W), .DST_MAX(999),
                        .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_sel(src_sel), .dst_sel(dst_sel), .len(len),
    .gnt(gnt), .err(err), .done(done), .mux_sel(mux_sel), .demux_sel(demux_sel),
    .route_busy(route_busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {int idx; int src; int dst; int len;} gexp_t;
  typedef struct {int idx; int at;} dexp_t;

  gexp_t gq[$];
  int    eq[$];
  dexp_t dq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_busy_end = -1;
  int m_src = 0;
  int m_dst = 0;
  int last_gnt_cyc = -1;
  int t_raise = 0;
  bit auto_drop = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sample();
    gexp_t g;
    dexp_t d;
    int    e;
    if (gnt != '0) begin
      if (gq.size() == 0) chk("gnt_unexp", 32'(gnt), 0);
      else begin
        g = gq.pop_front();
        chk("gnt", 32'(gnt), 32'(1) << g.idx);
        chk("mux_sel", 32'(mux_sel), g.src);
        chk("demux_sel", 32'(demux_sel), g.dst);
        chk("owner", 32'(owner), g.idx);
        m_busy_end   = cyc + g.len;
        m_src        = g.src;
        m_dst        = g.dst;
        last_gnt_cyc = cyc;
        d.idx = g.idx;
        d.at  = cyc + g.len + PIPE_LAT;
        dq.push_back(d);
      end
    end
    if (err != '0) begin
      if (eq.size() == 0) chk("err_unexp", 32'(err), 0);
      else begin
        e = eq.pop_front();
        chk("err", 32'(err), 32'(1) << e);
      end
    end
    if (done != '0) begin
      if (dq.size() == 0) chk("done_unexp", 32'(done), 0);
      else begin
        d = dq.pop_front();
        chk("done", 32'(done), 32'(1) << d.idx);
        chk("done_time", cyc, d.at);
      end
    end
    chk("route_busy", 32'(route_busy), 32'(cyc <= m_busy_end));
    if (cyc <= m_busy_end) begin
      chk("mux_hold", 32'(mux_sel), m_src);
      chk("demux_hold", 32'(demux_sel), m_dst);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    sample();
    if (auto_drop) req = req & ~(gnt | err);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_route(input int i, input int s, input int d, input int l);
    src_sel[i*SEL_W +: SEL_W] = SEL_W'(s);
    dst_sel[i*SEL_W +: SEL_W] = SEL_W'(d);
    len[i*LEN_W +: LEN_W]     = LEN_W'(l);
  endtask

  task automatic push_gnt(input int i, input int s, input int d, input int l);
    gexp_t g;
    g.idx = i; g.src = s; g.dst = d; g.len = l;
    gq.push_back(g);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mux"}, 32'(mux_sel), 0);
    chk({tag, "_demux"}, 32'(demux_sel), 0);
    chk({tag, "_busy"}, 32'(route_busy), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    src_sel = '0;
    dst_sel = '0;
    len     = '0;
    run(3);
    chk_all_zero("rst");
    #3 rst_n = 1'b1;
    run(2);

    // contention: all four with len 0, ptr at 0
    for (int i = 0; i < NREQ; i++) begin
      set_route(i, 100 + i, 200 + i, 0);
      push_gnt(i, 100 + i, 200 + i, 0);
    end
    req = 4'b1111;
    run(10);

    // single route
    set_route(2, 17, 300, 3);
    push_gnt(2, 17, 300, 3);
    req[2] = 1'b1;
    t_raise = cyc;
    run(1);
    chk("req_to_gnt", last_gnt_cyc, t_raise + 1);
    run(9);

    // illegal destination, then legal retry at the boundary
    set_route(1, 5, 1005, 2);
    eq.push_back(1);
    req[1] = 1'b1;
    run(4);
    set_route(1, 6, 999, 2);
    push_gnt(1, 6, 999, 2);
    req[1] = 1'b1;
    run(8);

    // inputs changing during hold have no effect
    set_route(0, 55, 66, 5);
    push_gnt(0, 55, 66, 5);
    req[0] = 1'b1;
    run(2);
    set_route(0, 77, 1023, 0);
    run(12);

    // reset in the third hold cycle
    set_route(2, 12, 34, 5);
    push_gnt(2, 12, 34, 5);
    req[2] = 1'b1;
    run(3);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    dq.delete();
    m_busy_end = -1;
    run(2);
    #3 rst_n = 1'b1;
    run(10);

    // fairness: 0 and 3 both held, expect 0,3,0,3 from ptr 0
    auto_drop = 1'b0;
    set_route(0, 400, 500, 1);
    set_route(3, 403, 503, 1);
    push_gnt(0, 400, 500, 1);
    push_gnt(3, 403, 503, 1);
    push_gnt(0, 400, 500, 1);
    push_gnt(3, 403, 503, 1);
    req = 4'b1001;
    run(7);
    req = '0;
    run(10);

    chk("gq_left", gq.size(), 0);
    chk("eq_left", eq.size(), 0);
    chk("dq_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_demux_route_arb.md
# mux_demux_route_arb

Round-robin arbiter and sequencer sharing the registered 1024:1 mux / 1:1024 demux I/O path between NREQ requesters. Each requester asks for a route, given as a source select, a destination select and a hold length. The block grants requesters one at a time and drives the path's mux/demux selects for the granted hold window. It reports completion once data has drained through the registered datapath.

## Interface
- NREQ, 4, number of requesters (2..16).
- SEL_W, 10, select width of mux and demux.
- LEN_W, 8, hold-length field width.
- DST_MAX, 999, highest legal destination; higher demux channels alias after output folding.
- PIPE_LAT, 2, datapath latency from select change to valid output (mux register + demux register).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- src_sel  in  NREQ*SEL_W  mux select per requester; requester i uses slice [i*SEL_W +: SEL_W].
- dst_sel  in  NREQ*SEL_W  demux select per requester, same slicing.
- len  in  NREQ*LEN_W  hold length minus one per requester.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- err  out  NREQ  one-cycle pulse; request rejected because dst_sel > DST_MAX.
- done  out  NREQ  one-cycle pulse when the route's last output is valid.
- mux_sel  out  SEL_W  registered mux select.
- demux_sel  out  SEL_W  registered demux select.
- route_busy  out  1  high while the selects carry a granted route.
- owner  out  $clog2(NREQ)  index of the current owner; valid when route_busy is high.

## Operation
- States: IDLE and HOLD.
- **Arbitration.** Candidates are the set req & ~gnt. The search runs from pointer ptr upward and wraps modulo NREQ; the first candidate wins. After a win, ptr = winner + 1 (mod NREQ).
- **Illegal destination.** If the winner's dst_sel > DST_MAX:
  - err[w] pulses and no route is set up;
  - ptr still advances;
  - the state stays as it was if in IDLE; if the hold was ending, the state goes to IDLE.
  - No further arbitration happens in that cycle.
- **IDLE.** On a legal winner w:
  - gnt[w] pulses;
  - load mux_sel, demux_sel, cnt = len[w] and owner = w;
  - set route_busy and go to HOLD.
- **HOLD.** cnt decrements each cycle. When cnt == 0 the cycle is the last hold cycle. In that cycle the block arbitrates again:
  - a legal winner is granted back-to-back with no bubble;
  - otherwise the state goes to IDLE and route_busy clears.
- Selects hold their value in IDLE and are not zeroed.
- Inputs are sampled only in the grant cycle. Changing req, src_sel, dst_sel or len during HOLD has no effect. A dropped req does not abort the hold.
- **Requester protocol.** The requester keeps req high until it sees gnt or err, then drops req on the next cycle. The ~gnt mask prevents an immediate re-grant when len = 0.
- **Completion.** A tag (valid, owner) enters a PIPE_LAT-deep shift register on the last hold cycle. done[owner] pulses when the tag exits.
  - Overlapping tags from back-to-back routes are independent.
  - done for different owners can fall on consecutive cycles.

## Timing
- Reset values: gnt, err, done = 0; mux_sel = demux_sel = 0; route_busy = 0; owner = 0; ptr = 0; cnt = 0; pipeline tags cleared; state = IDLE.
- Request to grant: if req rises in cycle t with the block idle, then gnt, the selects and route_busy are all visible after edge t+1, i.e. the same edge that registers the grant.
- A route occupies len+1 cycles of selects.
- done pulses PIPE_LAT cycles after the last hold cycle.
- Throughput: one route per len+1 cycles with no idle gap.
- Reset asserted mid-hold: all outputs return to their reset values immediately and asynchronously. In-flight done pulses are discarded and never issued.

## Structure
- A shared package holds:
  - the state enum (IDLE, HOLD);
  - SEL_W, LEN_W and DST_MAX defaults matching the 1024-channel datapath.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the request vector and ptr; outputs are winner index and any_valid. It is reused by other shared-resource blocks.
- The PIPE_LAT tag delay line stays inline in the top module.

## Test plan
- **Single route.** Reset, then req[2] = 1 with src = 17, dst = 300, len = 3 → after 1 edge:
  - gnt = 4'b0100, mux_sel = 17, demux_sel = 300, owner = 2;
  - route_busy high for 4 cycles;
  - done[2] 2 cycles after the last hold cycle.
- **Contention.** req = 4'b1111 held, all len = 0, ptr = 0 → grants in order 0, 1, 2, 3 on consecutive cycles with no bubbles. route_busy stays high for 4 cycles, and done[0..3] follow 2 cycles later, one per cycle.
- **Illegal destination.** req[1] with dst = 1005 → err[1] pulse, no gnt, route_busy stays 0. A following req[1] with dst = 999 is granted normally.
- **Mid-hold changes.** req[0] with len = 5 is granted; req[0] then drops and src_sel[0] changes during HOLD → selects unchanged for all 6 cycles and done[0] still pulses.
- **Reset mid-operation.** Assert rst_n = 0 in the 3rd hold cycle → all outputs 0 immediately. No done pulse ever appears for that route, and ptr = 0 on release.
- **Fairness.** req[3] is held while req[0] re-requests after every grant → grants alternate 0, 3, 0, 3; requester 3 is never starved.
